inst_fetcher: RTL and testbench
===============================

INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, instruction-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port icache_req_valid  output  1  fetch request outstanding.
REQ-007 SHALL have port icache_req_addr  output  32  fetch address, word-aligned.
REQ-008 SHALL have port icache_resp_valid  input  1  instruction word returned this cycle.
REQ-009 SHALL have port icache_resp_inst  input  32  returned instruction word.
REQ-010 SHALL have port inst_valid_out  output  1  queue head valid; feeds the decoder.
REQ-011 SHALL have port inst_out  output  32  queue-head instruction; drives decoder inst_in.
REQ-012 SHALL have port inst_pc_out  output  32  PC of queue-head instruction.
REQ-013 SHALL have port dispatch_ready_in  input  1  dispatcher consumes head this cycle.
REQ-014 SHALL have port redirect_valid_in  input  1  flush and restart fetch (mispredict/jump resolve).
REQ-015 SHALL have port redirect_pc_in  input  32  restart address.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_RESP, DISCARD.
REQ-017 SHALL assert icache_req_valid only in WAIT_RESP, icache_req_addr = fetch_pc, both stable until response.
REQ-018 IDLE -> WAIT_RESP when count < QUEUE_DEPTH and no redirect; otherwise stay IDLE.
REQ-019 In WAIT_RESP with icache_resp_valid: push {icache_resp_inst, fetch_pc} at tail, fetch_pc += 4 (mod 2^32).
REQ-020 After a push, SHALL stay in WAIT_RESP if post-update count < QUEUE_DEPTH, else go IDLE (back-to-back fetch, one request in flight max).
REQ-021 SHALL guarantee a push never hits a full queue; count only falls while a request is outstanding.
REQ-022 inst_valid_out SHALL equal (count != 0); inst_out/inst_pc_out SHALL show head entry combinationally, 0 when empty.
REQ-023 Pop SHALL occur when inst_valid_out && dispatch_ready_in; push and pop in same cycle leave count unchanged.
REQ-024 Head/tail pointers SHALL wrap modulo QUEUE_DEPTH; count range 0..QUEUE_DEPTH.
REQ-025 redirect_valid_in SHALL have highest priority: count, head, tail := 0; fetch_pc := redirect_pc_in; pop and push suppressed that cycle.
REQ-026 Redirect in WAIT_RESP without same-cycle response -> DISCARD; with same-cycle response -> response dropped, go IDLE.
REQ-027 DISCARD SHALL keep icache_req_valid low, drop the next icache_resp_valid word, then go IDLE; a further redirect in DISCARD only updates fetch_pc.
REQ-028 Redirect in IDLE SHALL go IDLE with new fetch_pc; fetch issues next cycle.
REQ-029 icache_resp_valid in IDLE SHALL be ignored.
REQ-030 With rdy_in low, no state, pointer, PC or FSM update SHALL occur, including redirect and response; outputs hold.
REQ-031 Latency: request raised cycle after entering WAIT_RESP; response in cycle N visible on inst_valid_out in N+1.

Reset
REQ-032 On rst_n_in low, SHALL asynchronously set state IDLE, fetch_pc RESET_PC, count/head/tail 0, all queue entries 0.
REQ-033 During reset, icache_req_valid, inst_valid_out, inst_out, inst_pc_out SHALL be 0.
REQ-034 Reset mid-WAIT_RESP SHALL abandon the request; a response arriving during reset is ignored.
REQ-035 First request SHALL appear the cycle after rst_n_in deasserts, addr RESET_PC, given rdy_in high.

Verification
REQ-036 Reset release, icache 1-cycle latency, ready=1 -> addrs 0,4,8 issued; inst_pc_out 0,4,8 in order, one per cycle.
REQ-037 dispatch_ready_in=0, 4 responses -> count 4, req_valid low, IDLE; ready=1 one cycle -> pop pc 0, new fetch addr 16.
REQ-038 Redirect to 0x100 while WAIT_RESP, response 2 cycles later -> response dropped, queue empty, next req addr 0x100.
REQ-039 Redirect and resp_valid same cycle -> word not queued, inst_valid_out 0 next cycle, req 0x100 following cycle.
REQ-040 rdy_in low 3 cycles with resp_valid pulsing -> no push/pop/PC change; resumes identically when rdy_in high.
REQ-041 Assert rst_n_in low mid-request with full queue -> outputs 0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - fetch-unit bus: global enable, icache request/response, decoder head, redirect
interface inst_fetcher_if;
    logic        rdy_in;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        dispatch_ready_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;

    modport master (
        input  rdy_in,
        output icache_req_valid,
        output icache_req_addr,
        input  icache_resp_valid,
        input  icache_resp_inst,
        output inst_valid_out,
        output inst_out,
        output inst_pc_out,
        input  dispatch_ready_in,
        input  redirect_valid_in,
        input  redirect_pc_in
    );

    modport slave (
        output rdy_in,
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_resp_valid,
        output icache_resp_inst,
        input  inst_valid_out,
        input  inst_out,
        input  inst_pc_out,
        output dispatch_ready_in,
        output redirect_valid_in,
        output redirect_pc_in
    );
endinterface

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - sequential instruction fetcher with one request in flight and a small instruction queue
module inst_fetcher #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    inst_fetcher_if.master bus
);
    localparam int             PW      = $clog2(QUEUE_DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, DISCARD} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    logic [31:0]    inst_q [QUEUE_DEPTH];
    logic [31:0]    pc_q   [QUEUE_DEPTH];
    logic           push, pop;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (bus.rdy_in) begin
            if (bus.redirect_valid_in) begin
                fetch_pc_d = bus.redirect_pc_in;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
                // An outstanding request must have its late response swallowed
                case (state_q)
                    WAIT_RESP: state_d = bus.icache_resp_valid ? IDLE : DISCARD;
                    DISCARD:   state_d = DISCARD;
                    default:   state_d = IDLE;
                endcase
            end else begin
                pop = (count_q != '0) && bus.dispatch_ready_in;
                case (state_q)
                    IDLE:      if (count_q < DEPTH_C) state_d = WAIT_RESP;
                    WAIT_RESP: push = bus.icache_resp_valid;
                    DISCARD:   if (bus.icache_resp_valid) state_d = IDLE;
                    default:   state_d = IDLE;
                endcase
                if (push) begin
                    tail_d     = tail_q + 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
                if (push) begin
                    state_d = (count_d < DEPTH_C) ? WAIT_RESP : IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (push) begin
                inst_q[tail_q] <= bus.icache_resp_inst;
                pc_q[tail_q]   <= fetch_pc_q;
            end
        end
    end

    assign bus.icache_req_valid = (state_q == WAIT_RESP);
    assign bus.icache_req_addr  = fetch_pc_q;
    assign bus.inst_valid_out   = (count_q != '0);
    assign bus.inst_out         = (count_q != '0) ? inst_q[head_q] : '0;
    assign bus.inst_pc_out      = (count_q != '0) ? pc_q[head_q]   : '0;
endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - scoreboard bench for inst_fetcher
module tb_inst_fetcher;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk;
    logic rst_n;
    inst_fetcher_if bus();

    inst_fetcher #(.QUEUE_DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        rdy_v, disp_v, redir_v, auto_ic, stale_v;
    logic [31:0] redir_pc_v;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Drive one cycle of inputs, update the scoreboard, then step past the next rising edge
    task automatic cycle();
        logic        resp;
        logic [31:0] word;
        logic [63:0] e;
        bus.rdy_in            = rdy_v;
        bus.dispatch_ready_in = disp_v;
        bus.redirect_valid_in = redir_v;
        bus.redirect_pc_in    = redir_pc_v;
        resp = 1'b0;
        word = '0;
        if (auto_ic && bus.icache_req_valid) begin
            resp = 1'b1;
            word = mk_inst(bus.icache_req_addr);
        end else if (stale_v) begin
            resp = 1'b1;
            word = 32'hDEAD_BEEF;
        end
        bus.icache_resp_valid = resp;
        bus.icache_resp_inst  = word;
        check_eq("head_valid", bus.inst_valid_out, exp_q.size() != 0);
        if (exp_q.size() == 0)
            check_eq("empty_head", {bus.inst_out, bus.inst_pc_out}, 64'h0);
        if (rdy_v) begin
            if (redir_v) begin
                exp_q.delete();
                exp_pc = redir_pc_v;
            end else begin
                if (bus.inst_valid_out && disp_v && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("pop_entry", {bus.inst_out, bus.inst_pc_out}, e);
                end
                if (resp && bus.icache_req_valid) begin
                    check_eq("req_addr", bus.icache_req_addr, exp_pc);
                    exp_q.push_back({mk_inst(exp_pc), exp_pc});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input logic resp_during);
        rst_n = 1'b0;
        bus.icache_resp_valid = resp_during;
        bus.icache_resp_inst  = 32'hBAD0_0BAD;
        bus.redirect_valid_in = 1'b0;
        exp_q.delete();
        exp_pc = RESET_PC;
        #1;
        check_eq("rst_req_valid", bus.icache_req_valid, 1'b0);
        check_eq("rst_inst_valid", bus.inst_valid_out, 1'b0);
        check_eq("rst_inst", bus.inst_out, 32'h0);
        check_eq("rst_pc", bus.inst_pc_out, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [97:0] snap;

    initial begin
        rst_n = 1'b0;
        bus.rdy_in = 1'b1;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_inst  = '0;
        bus.dispatch_ready_in = 1'b0;
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = '0;
        rdy_v = 1'b1; disp_v = 1'b0; redir_v = 1'b0; auto_ic = 1'b0; stale_v = 1'b0;
        redir_pc_v = '0;
        exp_pc = RESET_PC;
        @(posedge clk); #1;

        // Reset release, first request, streaming with same-cycle icache
        do_reset(1'b0);
        cycle();
        check_eq("first_req", {bus.icache_req_valid, bus.icache_req_addr}, {1'b1, RESET_PC});
        auto_ic = 1'b1; disp_v = 1'b1;
        run(10);

        // Fill queue with dispatch stalled, then pop once
        do_reset(1'b0);
        auto_ic = 1'b1; disp_v = 1'b0;
        run(8);
        check_eq("full_req_low", bus.icache_req_valid, 1'b0);
        check_eq("full_head_pc", bus.inst_pc_out, 32'h0);
        disp_v = 1'b1;
        cycle();
        disp_v = 1'b0; auto_ic = 1'b0;
        cycle();
        check_eq("refetch_addr", {bus.icache_req_valid, bus.icache_req_addr}, {1'b1, 32'd16});
        auto_ic = 1'b1;
        cycle();

        // Redirect while waiting, stale response two cycles later
        do_reset(1'b0);
        auto_ic = 1'b0; disp_v = 1'b0;
        cycle();
        redir_v = 1'b1; redir_pc_v = 32'h100;
        cycle();
        redir_v = 1'b0;
        cycle();
        check_eq("discard_req_low", bus.icache_req_valid, 1'b0);
        stale_v = 1'b1;
        cycle();
        stale_v = 1'b0;
        check_eq("after_discard_empty", bus.inst_valid_out, 1'b0);
        cycle();
        check_eq("redir_req", {bus.icache_req_valid, bus.icache_req_addr}, {1'b1, 32'h100});
        auto_ic = 1'b1; disp_v = 1'b1;
        run(4);

        // Redirect coinciding with a response
        redir_v = 1'b1; redir_pc_v = 32'h100;
        cycle();
        redir_v = 1'b0; auto_ic = 1'b0;
        check_eq("same_cycle_empty", bus.inst_valid_out, 1'b0);
        cycle();
        check_eq("same_cycle_req", {bus.icache_req_valid, bus.icache_req_addr}, {1'b1, 32'h100});

        // Freeze with rdy_in low while responses pulse
        auto_ic = 1'b1; disp_v = 1'b0;
        run(2);
        snap = {bus.icache_req_valid, bus.icache_req_addr, bus.inst_valid_out, bus.inst_out, bus.inst_pc_out};
        rdy_v = 1'b0; auto_ic = 1'b0; disp_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stale_v = (i != 1);
            redir_v = (i == 2); redir_pc_v = 32'h4000;
            cycle();
            check_eq("freeze_hold", {bus.icache_req_valid, bus.icache_req_addr, bus.inst_valid_out,
                                     bus.inst_out, bus.inst_pc_out}, snap);
        end
        stale_v = 1'b0; redir_v = 1'b0; rdy_v = 1'b1; auto_ic = 1'b1;
        run(8);

        // Reset with a partly full queue and a request outstanding
        disp_v = 1'b0;
        run(2);
        auto_ic = 1'b0;
        cycle();
        do_reset(1'b1);
        cycle();
        check_eq("restart_req", {bus.icache_req_valid, bus.icache_req_addr}, {1'b1, RESET_PC});
        auto_ic = 1'b1; disp_v = 1'b1;
        run(12);
        auto_ic = 1'b0;
        run(6);
        check_eq("drained", bus.inst_valid_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
